// File: rtl/pc_seq_if.sv
// ---------------------------------------------------------------------------
// pc_seq_if
//  Bundle of the signals exchanged between the branch/hazard logic and the
//  fetch PC sequencer.
//
//  master : branch unit / hazard side. It drives Stall, PcSel, BrPC, Halt and
//           Resume, and observes the sequencer outputs.
//  slave  : pc_sequencer. It drives Cur_PC, Flush, Halted, Misalign and
//           BrCount.
//
//  Stall    1     hazard stall, hold the PC this cycle
//  PcSel    1     redirect request
//  BrPC     32    redirect target
//  Halt     1     halt decoded in execute
//  Resume   1     restart request, only meaningful while halted
//  Cur_PC   PC_W  current fetch PC
//  Flush    1     kill younger in-flight instructions
//  Halted   1     core is halted
//  Misalign 1     sticky, a redirect target was not word aligned
//  BrCount  16    saturating count of accepted redirects
// ---------------------------------------------------------------------------
interface pc_seq_if #(
  parameter int PC_W = 9
);
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt;
  logic            Resume;
  logic [PC_W-1:0] Cur_PC;
  logic            Flush;
  logic            Halted;
  logic            Misalign;
  logic [15:0]     BrCount;

  modport master (
    output Stall, PcSel, BrPC, Halt, Resume,
    input  Cur_PC, Flush, Halted, Misalign, BrCount
  );

  modport slave (
    input  Stall, PcSel, BrPC, Halt, Resume,
    output Cur_PC, Flush, Halted, Misalign, BrCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//  Owns the fetch program counter. Each cycle the PC either advances by 4,
//  holds for a hazard stall, jumps to a branch-unit redirect target, or
//  freezes while the core is halted. Every accepted redirect is followed by
//  FLUSH_CYCLES cycles of Flush so the front end drops the wrong-path
//  instructions already fetched.
//
//  Parameters
//   PC_W          width of the fetch PC
//   RESET_PC      PC loaded on reset (word aligned)
//   FLUSH_CYCLES  Flush pulses per accepted redirect, 1..7
//
//  Ports
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of pc_seq_if (redirect/stall/halt inputs, PC and
//          status outputs)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state_reg,     state_next;
  logic [PC_W-1:0]  pc_reg,        pc_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic             flush_reg,     flush_next;
  logic             halted_reg,    halted_next;
  logic             misalign_reg,  misalign_next;
  logic [15:0]      br_count_reg,  br_count_next;

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  redirect_target;
  logic [CNT_W-1:0] flush_cnt_dec;
  logic             unused_brpc_hi;

  // Word-aligned redirect target: the low two bits are forced to zero and
  // any BrPC bits above the PC width are simply not looked at.
  genvar gi;
  generate
    for (gi = 0; gi < PC_W; gi++) begin : g_target
      if (gi < 2) begin : g_lo
        assign redirect_target[gi] = 1'b0;
      end else begin : g_hi
        assign redirect_target[gi] = bus.BrPC[gi];
      end
    end
  endgenerate

  assign unused_brpc_hi = ^bus.BrPC[31:PC_W];

  // Sequential PC increment wraps naturally at 2^PC_W.
  assign pc_inc        = pc_reg + PC_W'(4);
  assign flush_cnt_dec = flush_cnt_reg - CNT_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flush_cnt_next = flush_cnt_reg;
    flush_next     = 1'b0;
    halted_next    = 1'b0;
    misalign_next  = misalign_reg;
    br_count_next  = br_count_reg;

    case (state_reg)
      ST_RUN: begin
        if (bus.Halt) begin
          // Halt outranks a redirect in the same cycle; PC freezes here.
          state_next  = ST_HALT;
          halted_next = 1'b1;
        end else if (bus.PcSel) begin
          // A redirect overrides a simultaneous stall.
          pc_next        = redirect_target;
          misalign_next  = misalign_reg | (|bus.BrPC[1:0]);
          br_count_next  = (br_count_reg == 16'hFFFF) ? br_count_reg
                                                      : br_count_reg + 16'd1;
          flush_cnt_next = CNT_W'(FLUSH_CYCLES);
          flush_next     = 1'b1;
          state_next     = ST_FLUSH;
        end else if (!bus.Stall) begin
          pc_next = pc_inc;
        end
      end

      ST_FLUSH: begin
        // PcSel/Halt here belong to squashed wrong-path instructions, so
        // they are ignored. The counter keeps running even under a stall so
        // the flush length is fixed.
        flush_cnt_next = flush_cnt_dec;
        if (!bus.Stall) begin
          pc_next = pc_inc;
        end
        if (flush_cnt_dec == '0) begin
          flush_next = 1'b0;
          state_next = ST_RUN;
        end else begin
          flush_next = 1'b1;
        end
      end

      ST_HALT: begin
        // Only Resume is honoured; it wins over a simultaneous Halt.
        if (bus.Resume) begin
          pc_next     = pc_inc;
          halted_next = 1'b0;
          state_next  = ST_RUN;
        end else begin
          halted_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RUN;
      pc_reg        <= RESET_PC;
      flush_cnt_reg <= '0;
      flush_reg     <= 1'b0;
      halted_reg    <= 1'b0;
      misalign_reg  <= 1'b0;
      br_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      flush_cnt_reg <= flush_cnt_next;
      flush_reg     <= flush_next;
      halted_reg    <= halted_next;
      misalign_reg  <= misalign_next;
      br_count_reg  <= br_count_next;
    end
  end

  assign bus.Cur_PC   = pc_reg;
  assign bus.Flush    = flush_reg;
  assign bus.Halted   = halted_reg;
  assign bus.Misalign = misalign_reg;
  assign bus.BrCount  = br_count_reg;

endmodule
